// File: rtl/timer32_poll_master.sv
// Bus initiator for a timer32 slave: configures it on start, then polls STATUS.
// Build macro TMR_POLL_ONESHOT_EN stops polling after the first flagged read.
module timer32_poll_master #(
    parameter int POLL_GAP = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      period_in,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata,
    output logic             bus_wren,
    output logic             bus_rden,
    output logic [1:0]       bus_addr,
    output logic             busy,
    output logic             irq,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       last_status
);

`ifdef TMR_POLL_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, WR_PR, WR_TMR, WR_CTRL, POLL_WAIT, POLL_RD, STOP_WR
    } state_e;

    state_e state_q, state_d, poll_st;

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             stop_pend_q, stop_pend_d;
    logic             stop_now, take_start, flagged;
    logic             wren_q, wren_d, rden_q, rden_d, busy_q, busy_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [2:0]       status_q, status_d;
    logic             unused_rdata;

    assign unused_rdata = ^bus_rdata[31:3];
    assign stop_now     = stop_pend_q | stop;
    assign take_start   = (state_q == IDLE) & start;
    assign flagged      = (state_q == POLL_RD) & bus_rdata[1];
    assign poll_st      = (POLL_GAP == 0) ? POLL_RD : POLL_WAIT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = WR_PR;
            WR_PR:     state_d = WR_TMR;
            WR_TMR:    state_d = WR_CTRL;
            WR_CTRL:   state_d = stop_now ? STOP_WR : poll_st;
            POLL_WAIT: begin
                if (stop_now)               state_d = STOP_WR;
                else if (gap_q == GAP_LAST) state_d = POLL_RD;
            end
            POLL_RD: begin
                if (stop_now || (ONESHOT && bus_rdata[1])) state_d = STOP_WR;
                else                                       state_d = poll_st;
            end
            STOP_WR:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they can be registered.
    always_comb begin
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        addr_d  = 2'd0;
        wdata_d = 32'd0;
        busy_d  = (state_d != IDLE);
        unique case (state_d)
            WR_PR:   begin wren_d = 1'b1; addr_d = 2'd1; wdata_d = period_in; end
            WR_TMR:  begin wren_d = 1'b1; addr_d = 2'd0; end
            WR_CTRL: begin wren_d = 1'b1; addr_d = 2'd2; wdata_d = 32'h1; end
            POLL_RD: begin rden_d = 1'b1; addr_d = 2'd2; end
            STOP_WR: begin wren_d = 1'b1; addr_d = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        gap_d       = (state_q == POLL_WAIT) ? gap_q + 1'b1 : '0;
        stop_pend_d = stop_pend_q;
        if (state_q == STOP_WR)
            stop_pend_d = 1'b0;
        else if (stop && (state_q != IDLE || start))
            stop_pend_d = 1'b1;
        irq_d    = flagged;
        match_d  = match_q;
        status_d = status_q;
        if (take_start) begin
            match_d  = '0;
            status_d = '0;
        end else if (state_q == POLL_RD) begin
            status_d = bus_rdata[2:0];
            if (flagged) match_d = match_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            addr_q      <= 2'd0;
            wdata_q     <= 32'd0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
            match_q     <= '0;
            status_q    <= 3'd0;
        end else begin
            gap_q       <= gap_d;
            stop_pend_q <= stop_pend_d;
            wren_q      <= wren_d;
            rden_q      <= rden_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            irq_q       <= irq_d;
            match_q     <= match_d;
            status_q    <= status_d;
        end
    end

    assign bus_wren    = wren_q;
    assign bus_rden    = rden_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign busy        = busy_q;
    assign irq         = irq_q;
    assign match_count = match_q;
    assign last_status = status_q;

endmodule

// File: tb/tb_timer32_poll_master.sv
// Bench for timer32_poll_master with a small behavioural timer32 slave.
// Build with TMR_POLL_ONESHOT_EN to exercise the one-shot variant.
module tb_timer32_poll_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period_in = 32'd0;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_wren, bus_rden;
    logic [1:0]  bus_addr;
    logic        busy, irq;
    logic [15:0] match_count;
    logic [2:0]  last_status;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    timer32_poll_master #(.POLL_GAP(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .period_in(period_in), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_wren(bus_wren),
        .bus_rden(bus_rden), .bus_addr(bus_addr), .busy(busy),
        .irq(irq), .match_count(match_count),
        .last_status(last_status)
    );

    // Timer32 slave model: flag is sticky until a STATUS read.
    wire         srst = ~reset;
    logic [31:0] s_tmr, s_pr;
    logic        s_en, s_flag, s_tog;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            s_tmr <= 0; s_pr <= 0;
            s_en <= 0; s_flag <= 0; s_tog <= 0;
        end else if (bus_wren) begin
            case (bus_addr)
                2'd0: s_tmr <= bus_wdata;
                2'd1: s_pr <= bus_wdata;
                default: {s_tog, s_flag, s_en} <= bus_wdata[2:0];
            endcase
        end else begin
            if (bus_rden && bus_addr == 2'd2) s_flag <= 1'b0;
            if (s_en) begin
                if (s_tmr == s_pr) begin
                    s_tmr <= 0; s_flag <= 1'b1; s_tog <= ~s_tog;
                end else begin
                    s_tmr <= s_tmr + 1;
                end
            end
        end
    end

    always_comb begin
        case (bus_addr)
            2'd0: bus_rdata = s_tmr;
            2'd1: bus_rdata = s_pr;
            default: bus_rdata = {29'd0, s_tog, s_flag, s_en};
        endcase
    end

    always @(posedge clk) cyc++;

    // Bus monitor, sampled mid-cycle.
    logic [1:0]  wl_addr [16];
    logic [31:0] wl_data [16];
    int          wl_cyc  [16];
    int wn = 0, strobes = 0, flag_reads = 0;
    int irq_cnt = 0, irq_wide = 0, both = 0;
    logic irq_prev = 1'b0;

    always @(negedge clk) begin
        if (bus_wren && wn < 16) begin
            wl_addr[wn] = bus_addr;
            wl_data[wn] = bus_wdata;
            wl_cyc[wn]  = cyc;
            wn++;
        end
        if (bus_wren || bus_rden) strobes++;
        if (bus_wren && bus_rden) both++;
        if (bus_rden && bus_addr == 2'd2 && bus_rdata[1]) flag_reads++;
        if (irq) irq_cnt++;
        if (irq && irq_prev) irq_wide++;
        irq_prev = irq;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wn = 0; strobes = 0; flag_reads = 0;
        irq_cnt = 0; irq_wide = 0; both = 0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        check({"idle_", tag}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_wr(input string tag, input int i,
                            input logic [1:0] a, input logic [31:0] d);
        check({tag, "_addr"}, {62'd0, wl_addr[i]}, {62'd0, a});
        check({tag, "_data"}, {32'd0, wl_data[i]}, {32'd0, d});
    endtask

    int c0;

    initial begin
        tick(3);
        check("rst_busy", {63'd0, busy}, 0);
        check("rst_irq", {63'd0, irq}, 0);
        check("rst_wren", {63'd0, bus_wren}, 0);
        check("rst_rden", {63'd0, bus_rden}, 0);
        check("rst_addr", {62'd0, bus_addr}, 0);
        check("rst_wdata", {32'd0, bus_wdata}, 0);
        check("rst_match", {48'd0, match_count}, 0);
        check("rst_status", {61'd0, last_status}, 0);
        reset = 1'b1;
        tick(1);
        clear_mon();
        tick(20);
        check("idle_strobes", strobes, 0);
        check("idle_busy", {63'd0, busy}, 0);

        // Configure with period 5.
        clear_mon();
        c0 = cyc;
        start = 1'b1; period_in = 32'd5;
        tick(1);
        start = 1'b0; period_in = 32'd0;
        tick(5);
        check("cfg_nwr", wn, 3);
        check("cfg_cyc0", wl_cyc[0], c0 + 1);
        check("cfg_cyc1", wl_cyc[1], c0 + 2);
        check("cfg_cyc2", wl_cyc[2], c0 + 3);
        check_wr("cfg_pr", 0, 2'd1, 32'd5);
        check_wr("cfg_tmr", 1, 2'd0, 32'd0);
        check_wr("cfg_ctrl", 2, 2'd2, 32'd1);
        check("slv_pr", {32'd0, s_pr}, 5);

`ifndef TMR_POLL_ONESHOT_EN
        check("slv_en", {63'd0, s_en}, 1);
        tick(100);
        check("run_status_en", {63'd0, last_status[0]}, 1);
        check("run_flagged", {63'd0, flag_reads > 0}, 1);
        check("run_irq_wide", irq_wide, 0);
        check("run_both", both, 0);
        check("run_busy", {63'd0, busy}, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("run", 20);
        tick(3);
        check("run_match", {48'd0, match_count}, flag_reads);
        check("run_irq_cnt", irq_cnt, flag_reads);
        check("run_slv_en", {63'd0, s_en}, 0);
        check_wr("run_stop", wn - 1, 2'd2, 32'd0);
`else
        wait_idle("oneshot_p5", 200);
        tick(3);
        clear_mon();
        start = 1'b1; period_in = 32'd3;
        tick(1);
        start = 1'b0;
        wait_idle("oneshot", 200);
        tick(5);
        check("os_irq_cnt", irq_cnt, 1);
        check("os_match", {48'd0, match_count}, 1);
        check("os_nwr", wn, 4);
        check_wr("os_stop", 3, 2'd2, 32'd0);
        check("os_slv_en", {63'd0, s_en}, 0);
`endif

        // stop arriving while WR_TMR is on the bus.
        clear_mon();
        start = 1'b1; period_in = 32'd7;
        tick(1);
        start = 1'b0;
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("stop_tmr", 20);
        tick(3);
        check("st_nwr", wn, 4);
        check_wr("st_pr", 0, 2'd1, 32'd7);
        check_wr("st_ctrl", 2, 2'd2, 32'd1);
        check_wr("st_stop", 3, 2'd2, 32'd0);
        check("st_gap", wl_cyc[3] - wl_cyc[2], 1);
        check("st_rden", strobes, 4);
        check("st_slv_en", {63'd0, s_en}, 0);

        // start and stop together, then a start while busy.
        clear_mon();
        start = 1'b1; stop = 1'b1; period_in = 32'd9;
        tick(1);
        stop = 1'b0; period_in = 32'd11;
        tick(1);
        start = 1'b0;
        wait_idle("ss", 20);
        tick(10);
        check("ss_nwr", wn, 4);
        check_wr("ss_pr", 0, 2'd1, 32'd9);
        check_wr("ss_stop", 3, 2'd2, 32'd0);
        check("ss_match", {48'd0, match_count}, 0);

        // Reset in the middle of configuration.
        clear_mon();
        start = 1'b1; period_in = 32'd4;
        tick(1);
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_wren", {63'd0, bus_wren}, 0);
        check("mid_rst_busy", {63'd0, busy}, 0);
        tick(2);
        reset = 1'b1;
        clear_mon();
        tick(10);
        check("mid_rst_quiet", strobes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
